// File: rtl/qr_pkg.sv
// Shared state encodings and sizing constants for the QR stage sequencer.
package qr_pkg;

    localparam int unsigned QR_STATE_W         = 3;
    localparam int unsigned QR_TIMEOUT_DEFAULT = 64;
    localparam int unsigned QR_RUN_CNT_W       = 16;

    typedef enum logic [QR_STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_ACK        = 3'd3,
        ST_DONE       = 3'd4,
        ST_ERROR      = 3'd5
    } qr_state_e;

endpackage

// File: rtl/stage_watchdog.sv
// Load/increment cycle counter with a terminal-count flag at TIMEOUT-1.
module stage_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic inc,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload to zero on load; count up while enabled, holding at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/qr_stage_sequencer.sv
// Sequences the Gram-Schmidt column stages in order with a per-stage watchdog
// and a saturating run-length counter.
module qr_stage_sequencer
    import qr_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned TIMEOUT    = QR_TIMEOUT_DEFAULT,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    done_ack,
    input  logic                    clear_err,
    input  logic [NUM_STAGES-1:0]   stage_idle,
    input  logic [NUM_STAGES-1:0]   stage_ready,
    output logic [NUM_STAGES-1:0]   stage_enable,
    output logic [NUM_STAGES-1:0]   stage_accept,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [IDX_W-1:0]        err_stage,
    output logic [QR_RUN_CNT_W-1:0] run_cycles
);

    // Stage vectors padded to the full index range so idx selects are exact-width.
    localparam int unsigned IDX_N = 2 ** IDX_W;

    qr_state_e                state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [QR_RUN_CNT_W-1:0]  run_q, run_d;
    logic [IDX_W-1:0]         err_stage_q, err_stage_d;
    logic [NUM_STAGES-1:0]    enable_q, enable_d;
    logic [NUM_STAGES-1:0]    accept_q, accept_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     terr_q, terr_d;

    logic [IDX_N-1:0]         ready_pad_c;
    logic [IDX_N-1:0]         idle_pad_c;
    logic [IDX_N-1:0]         onehot_c;
    logic                     wd_tc_c;
    logic                     in_run_c;

    assign ready_pad_c = IDX_N'(stage_ready);
    assign idle_pad_c  = IDX_N'(stage_idle);
    assign in_run_c    = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_READY) ||
                         (state_q == ST_ACK);

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state_q == ST_LAUNCH),
        .inc     (state_q == ST_WAIT_READY),
        .tc_c    (wd_tc_c)
    );

    // Next state, stage index, run counter, and registered output decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_d       = run_q;
        err_stage_d = err_stage_q;
        onehot_c    = '0;
        enable_d    = '0;
        accept_d    = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        terr_d      = 1'b0;

        if (in_run_c && (run_q != {QR_RUN_CNT_W{1'b1}})) begin
            run_d = run_q + QR_RUN_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start && (&stage_idle)) begin
                    state_d = ST_LAUNCH;
                    idx_d   = '0;
                    run_d   = '0;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                // A ready arriving on the terminal watchdog cycle still wins.
                if (ready_pad_c[idx_q]) begin
                    state_d = ST_ACK;
                end else if (wd_tc_c) begin
                    state_d     = ST_ERROR;
                    err_stage_d = idx_q;
                end
            end
            ST_ACK: begin
                if (idle_pad_c[idx_q]) begin
                    if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_DONE: begin
                if (done_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (clear_err) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        onehot_c = IDX_N'(1) << idx_d;
        if (state_d == ST_LAUNCH) begin
            enable_d = onehot_c[NUM_STAGES-1:0];
        end
        if (state_d == ST_ACK) begin
            accept_d = onehot_c[NUM_STAGES-1:0];
        end
        busy_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT_READY) ||
                 (state_d == ST_ACK);
        done_d = (state_d == ST_DONE);
        terr_d = (state_d == ST_ERROR);
    end

    // State, index, counters and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            run_q       <= '0;
            err_stage_q <= '0;
            enable_q    <= '0;
            accept_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            err_stage_q <= err_stage_d;
            enable_q    <= enable_d;
            accept_q    <= accept_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            terr_q      <= terr_d;
        end
    end

    assign stage_enable = enable_q;
    assign stage_accept = accept_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_err  = terr_q;
    assign err_stage    = err_stage_q;
    assign run_cycles   = run_q;

endmodule

// File: doc/qr_stage_sequencer.md
Name: qr_stage_sequencer

Overview:
- Top-level scheduler for the Gram-Schmidt QR pipeline of the ZF detector.
- Runs NUM_STAGES column stages in fixed order: stage 0 first, then 1, and so on. Examples are Q column normalisation, the Q_col2 pre-stage and the Q_col3 pre-stage.
- Uses each stage's existing handshake: enable in, accept_out (idle), ready_out, accept_in.
- Guards each stage with a watchdog timeout and reports the cycle count of the whole run.

Parameters:
- NUM_STAGES, 3, number of sequenced column stages (2..8).
- TIMEOUT, 64, maximum cycles a stage may take in WAIT_READY before the sequencer flags an error.
- IDX_W, 3, width of the stage index; must satisfy 2**IDX_W >= NUM_STAGES.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level request to run one full decomposition.
- done_ack  in  1  consumer has taken the result; releases DONE.
- clear_err  in  1  releases ERROR.
- stage_idle  in  NUM_STAGES  accept_out of each stage; high means the stage is in IDLE.
- stage_ready  in  NUM_STAGES  ready_out of each stage.
- stage_enable  out  NUM_STAGES  one-hot enable pulse to a stage.
- stage_accept  out  NUM_STAGES  one-hot accept_in to a stage.
- busy  out  1  high in LAUNCH, WAIT_READY and ACK.
- done  out  1  run complete; held until done_ack.
- timeout_err  out  1  watchdog fired; held until clear_err.
- err_stage  out  IDX_W  index of the stage that timed out.
- run_cycles  out  16  cycles from LAUNCH of stage 0 to entry into DONE; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, idx=0, watchdog=0, run_cycles=0, err_stage=0. All outputs are 0.
- Outputs are decoded only from registered state and idx. There is no combinational path from any input to any output.
- IDLE:
  - If start=1 and stage_idle is all-ones, go to LAUNCH with idx=0 and clear run_cycles.
  - If start=1 but any stage is not idle, stay in IDLE.
- LAUNCH:
  - stage_enable[idx]=1 for exactly one cycle.
  - Next state is WAIT_READY, with the watchdog loaded to 0.
  - First enable appears 1 cycle after start is sampled.
- WAIT_READY:
  - Watchdog increments each cycle.
  - If stage_ready[idx]=1, go to ACK.
  - Otherwise, if watchdog==TIMEOUT-1, go to ERROR and set err_stage=idx.
  - If ready and the timeout occur in the same cycle, ready wins.
- ACK:
  - stage_accept[idx]=1 is held until stage_idle[idx]=1 is sampled.
  - Then, if idx==NUM_STAGES-1, go to DONE; otherwise increment idx and go to LAUNCH.
  - The stage drops ready_out one cycle after it leaves READY. That stale ready is never sampled, because idx has already advanced.
- DONE:
  - done=1 and busy=0.
  - On done_ack=1, go to IDLE.
  - start is ignored while in DONE.
- ERROR:
  - timeout_err=1; all enables and accepts are 0.
  - On clear_err=1, go to IDLE.
  - If start=1 arrives in the same cycle as clear_err, it is evaluated in IDLE on the next cycle.
  - A hung stage stays busy until it is reset through reset_n. The IDLE all-idle check blocks any relaunch until then.
- run_cycles counts every cycle in LAUNCH, WAIT_READY and ACK. It holds its value in DONE and ERROR and clears on the next accepted start.
- Reset mid-run aborts immediately to IDLE with no enable or accept pulse. Stages are reset by the same reset_n.
- Watchdog width is clog2(TIMEOUT+1) bits. It never wraps, because it is reloaded in LAUNCH.

Decomposition:
- Shared package qr_pkg holds:
  - the state encodings IDLE=0, LAUNCH=1, WAIT_READY=2, ACK=3, DONE=4, ERROR=5 (3 bits);
  - QR_TIMEOUT_DEFAULT=64;
  - QR_RUN_CNT_W=16.
- One sub-module, stage_watchdog: a load/increment counter with a terminal-count flag, parameterised by TIMEOUT.
- FSM, idx register, one-hot decode and the run_cycles saturating counter stay in qr_stage_sequencer.

Test Plan:
- Nominal, NUM_STAGES=3:
  - Stimulus: stage models return ready 5, 7 and 7 cycles after enable, then go idle 1 cycle after accept; start pulsed.
  - Required: enables fire on stages 0, 1, 2 in order, one cycle each.
  - Required: done rises and run_cycles equals the summed LAUNCH, WAIT_READY and ACK cycle counts. Record this value exactly on the first run and check it is identical on repeats.
- Busy-at-start: start=1 while stage_idle=3'b101 -> stays in IDLE with no enable; stage_idle goes to 3'b111 -> LAUNCH on the next cycle.
- Timeout, TIMEOUT=8:
  - Stimulus: stage 1 never asserts ready.
  - Required: timeout_err=1 and err_stage=1 exactly 8 cycles after stage 1's WAIT_READY entry, with no stage_enable[2].
  - Then: clear_err -> IDLE.
- Ready and timeout together: stage_ready[idx] rises in the same cycle that watchdog==TIMEOUT-1 -> ACK, not ERROR.
- DONE hold: done stays high for 10 cycles with done_ack=0, and start=1 is ignored; done_ack=1 -> IDLE; a held start then launches stage 0 one cycle later.
- Reset mid-run: reset_n low during stage 1's WAIT_READY -> all outputs 0 immediately and state IDLE; after release, no spurious enable without start.
